// File: rtl/sccomp_io_pkg.sv
// Shared definitions for the sccomp memory-mapped I/O peripherals:
// register offsets, peripheral base addresses and sizing helpers.
package sccomp_io_pkg;

  localparam logic [1:0] LEVEL_OFS = 2'd0;
  localparam logic [1:0] RISE_OFS  = 2'd1;
  localparam logic [1:0] FALL_OFS  = 2'd2;
  localparam logic [1:0] MASK_OFS  = 2'd3;

  localparam logic [31:0] LED_BASE = 32'hFFFF_0000;
  localparam logic [31:0] SW_BASE  = 32'hFFFF_0004;

  // Bits needed to count 0..max_count-1, never less than one.
  function automatic int cnt_width(input int max_count);
    if (max_count > 1) begin
      return $clog2(max_count);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounced input: synchroniser chain, tick-qualified stability
// counter and accepted-level flop, with single-cycle edge pulses.
module debounce_ch
  import sccomp_io_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_TICKS = 16
) (
  input  logic clk,
  input  logic rstn_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic                   level_r;
  logic                   sync_s;
  logic                   accept_s;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Metastability chain for the asynchronous raw input.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw_i};
    end
  end

  // Acceptance happens on the tick that would otherwise push cnt past its last value.
  always_comb begin
    accept_s = 1'b0;
    if ((sync_s != level_r) && tick_i && (cnt_r == CNT_LAST)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Stability counter and accepted level; any agreement with level restarts qualification.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= 1'b0;
    end else if (sync_s == level_r) begin
      cnt_r   <= {CW{1'b0}};
    end else if (accept_s) begin
      cnt_r   <= {CW{1'b0}};
      level_r <= sync_s;
    end else if (tick_i) begin
      cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  assign level_o = level_r;
  assign rise_o  = accept_s & sync_s;
  assign fall_o  = accept_s & ~sync_s;

endmodule

// File: rtl/mmio_debounce_bank.sv
// Memory-mapped bank of debounced inputs with sticky rise/fall flags,
// W1C clearing, an interrupt mask and a registered interrupt.
module mmio_debounce_bank
  import sccomp_io_pkg::*;
#(
  parameter int N_CH         = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 16
) (
  input  logic            clk,
  input  logic            rstn_i,
  input  logic [N_CH-1:0] raw_i,
  input  logic            sel_i,
  input  logic            we_i,
  input  logic [1:0]      addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic [N_CH-1:0] level_o,
  output logic            irq_o
);

  localparam int            PW       = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]   pre_r;
  logic            tick_s;
  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] rise_s;
  logic [N_CH-1:0] fall_s;
  logic [N_CH-1:0] rise_r;
  logic [N_CH-1:0] fall_r;
  logic [N_CH-1:0] mask_r;
  logic [N_CH-1:0] rise_clr_s;
  logic [N_CH-1:0] fall_clr_s;
  logic            mask_we_s;
  logic            irq_r;
  logic [31:0]     rdata_s;
  logic            unused_s;

  assign tick_s   = (pre_r == PRE_LAST);
  assign unused_s = ^wdata_i;

  // Shared sample-tick prescaler.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      pre_r <= {PW{1'b0}};
    end else if (tick_s) begin
      pre_r <= {PW{1'b0}};
    end else begin
      pre_r <= pre_r + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS)
    ) u_ch (
      .clk    (clk),
      .rstn_i (rstn_i),
      .tick_i (tick_s),
      .raw_i  (raw_i[g]),
      .level_o(level_s[g]),
      .rise_o (rise_s[g]),
      .fall_o (fall_s[g])
    );
  end

  // Bus write decode; LEVEL writes and unselected cycles fall through to no-op.
  always_comb begin
    rise_clr_s = {N_CH{1'b0}};
    fall_clr_s = {N_CH{1'b0}};
    mask_we_s  = 1'b0;
    if (sel_i && we_i) begin
      case (addr_i)
        RISE_OFS: rise_clr_s = wdata_i[N_CH-1:0];
        FALL_OFS: fall_clr_s = wdata_i[N_CH-1:0];
        MASK_OFS: mask_we_s  = 1'b1;
        default:  mask_we_s  = 1'b0;
      endcase
    end else begin
      mask_we_s = 1'b0;
    end
  end

  // Sticky edge flags; a new edge outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      rise_r <= {N_CH{1'b0}};
      fall_r <= {N_CH{1'b0}};
    end else begin
      rise_r <= (rise_r & ~rise_clr_s) | rise_s;
      fall_r <= (fall_r & ~fall_clr_s) | fall_s;
    end
  end

  // Interrupt enable register.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      mask_r <= {N_CH{1'b0}};
    end else if (mask_we_s) begin
      mask_r <= wdata_i[N_CH-1:0];
    end else begin
      mask_r <= mask_r;
    end
  end

  // Registered interrupt from masked pending flags.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |((rise_r | fall_r) & mask_r);
    end
  end

  // Zero-latency read mux; unused upper bits read as zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (addr_i)
      LEVEL_OFS: rdata_s = 32'(level_s);
      RISE_OFS:  rdata_s = 32'(rise_r);
      FALL_OFS:  rdata_s = 32'(fall_r);
      MASK_OFS:  rdata_s = 32'(mask_r);
      default:   rdata_s = 32'h0000_0000;
    endcase
  end

  assign rdata_o = rdata_s;
  assign level_o = level_s;
  assign irq_o   = irq_r;

endmodule
